// File: rtl/fb_coef_reader_if.sv
// rtl/fb_coef_reader_if.sv - table fetch and coefficient stream bundle for fb_coef_reader
interface fb_coef_reader_if #(
    parameter int WIDTH_A = 12
) ();
    logic [WIDTH_A-1:0] rom_addr;
    logic [15:0]        rom_coef;
    logic [15:0]        coef_data;
    logic [WIDTH_A-1:0] coef_idx;
    logic               coef_valid;
    logic               coef_ready;
    logic               coef_last;

    modport master (
        output rom_addr,
        input  rom_coef,
        output coef_data,
        output coef_idx,
        output coef_valid,
        input  coef_ready,
        output coef_last
    );

    modport slave (
        input  rom_addr,
        output rom_coef,
        input  coef_data,
        input  coef_idx,
        input  coef_valid,
        output coef_ready,
        input  coef_last
    );
endinterface

// File: rtl/fb_coef_reader.sv
// rtl/fb_coef_reader.sv - windowed sequential reader of the twiddle table onto a valid/ready stream
module fb_coef_reader #(
    parameter int WIDTH_A = 12,
    parameter int DEPTH   = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH_A-1:0] base,
    input  logic [WIDTH_A-1:0] len,
    output logic               busy,
    output logic               done,
    fb_coef_reader_if.master   cif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [WIDTH_A-1:0] ptr;
    logic [WIDTH_A-1:0] remaining;
    logic               load;

    // The table answers in the same cycle, so the address is decoded, not registered.
    always_comb begin
        cif.rom_addr = (state == IDLE) ? '0 : ptr;
    end

    assign load = !cif.coef_valid || cif.coef_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            remaining      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cif.coef_data  <= '0;
            cif.coef_idx   <= '0;
            cif.coef_valid <= 1'b0;
            cif.coef_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            ptr       <= (base >= WIDTH_A'(DEPTH)) ? '0 : base;
                            remaining <= len;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A consumed beat is replaced on the same edge, so no bubble at full rate.
                    if (load) begin
                        cif.coef_data  <= cif.rom_coef;
                        cif.coef_idx   <= ptr;
                        cif.coef_valid <= 1'b1;
                        cif.coef_last  <= (remaining == WIDTH_A'(1));
                        ptr            <= (ptr == WIDTH_A'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                        remaining      <= remaining - 1'b1;
                        if (remaining == WIDTH_A'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cif.coef_valid && cif.coef_ready) begin
                        cif.coef_valid <= 1'b0;
                        cif.coef_last  <= 1'b0;
                        done           <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_coef_reader.sv
// tb/tb_fb_coef_reader.sv - directed self-checking bench for fb_coef_reader
module tb_fb_coef_reader;
    localparam int WA    = 12;
    localparam int DEPTH = 40;

    logic          clk;
    logic          rst;
    logic          start;
    logic [WA-1:0] base;
    logic [WA-1:0] len;
    logic          busy;
    logic          done;

    int total;
    int bad;

    fb_coef_reader_if #(.WIDTH_A(WA)) cif ();

    fb_coef_reader #(.WIDTH_A(WA), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .base  (base),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .cif   (cif)
    );

    assign cif.rom_coef = 16'h1000 + 16'(cif.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int q_idx[$];
    int q_data[$];
    int q_last[$];
    int first_valid_k;
    int done_k;
    int busy_k1;
    int busy_seen;
    int busy_at_done;
    int held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input int b, input int l);
        start = 1'b1;
        base  = WA'(b);
        len   = WA'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one window from the current negedge; k counts cycles after the start cycle.
    task automatic run(input int b, input int l, input int stall_from, input int stall_cnt,
                       input int mid_start_k, input int budget);
        q_idx.delete();
        q_data.delete();
        q_last.delete();
        first_valid_k = -1;
        done_k        = -1;
        busy_seen     = 0;
        busy_at_done  = -1;
        held          = 0;
        do_start(b, l);
        busy_k1 = int'(busy);
        for (int k = 1; k <= budget; k++) begin
            cif.coef_ready = !(k >= stall_from && k < stall_from + stall_cnt);
            start = (k == mid_start_k);
            if (k == mid_start_k) begin
                base = WA'(30);
                len  = WA'(1);
            end
            if (busy) busy_seen = 1;
            if (cif.coef_valid && first_valid_k < 0) first_valid_k = k;
            if (cif.coef_valid && !cif.coef_ready && cif.coef_idx == WA'(b)
                && cif.coef_data == 16'h1000 + 16'(b)) held++;
            if (cif.coef_valid && cif.coef_ready) begin
                q_idx.push_back(int'(cif.coef_idx));
                q_data.push_back(int'(cif.coef_data));
                q_last.push_back(int'(cif.coef_last));
            end
            if (done) begin
                done_k       = k;
                busy_at_done = int'(busy);
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        cif.coef_ready = 1'b1;
        if (done_k < 0) chk("timeout", 1, 0);
    endtask

    task automatic check_beats(input string tag, input int b, input int l);
        int s;
        int e;
        s = (b >= DEPTH) ? 0 : b;
        chk({tag, "_count"}, q_idx.size(), l);
        for (int i = 0; i < q_idx.size() && i < l; i++) begin
            e = (s + i) % DEPTH;
            chk({tag, "_idx"}, q_idx[i], e);
            chk({tag, "_data"}, q_data[i], 32'h1000 + e);
            chk({tag, "_last"}, q_last[i], (i == l - 1) ? 1 : 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        cif.coef_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_valid", cif.coef_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", cif.rom_addr, 0);
        chk("rst_data", cif.coef_data, 0);

        // full sweep
        run(0, 40, 0, 0, 0, 100);
        check_beats("sweep", 0, 40);
        chk("sweep_first", first_valid_k, 2);
        chk("sweep_done_k", done_k, 42);
        chk("sweep_busy_k1", busy_k1, 1);
        chk("sweep_busy_done", busy_at_done, 0);

        // back-to-back: started in the done cycle of the sweep
        run(38, 4, 0, 0, 0, 40);
        check_beats("wrap", 38, 4);
        chk("b2b_first", first_valid_k, 2);
        chk("wrap_done_k", done_k, 6);

        // backpressure on the first beat
        run(5, 3, 2, 3, 0, 40);
        check_beats("bp", 5, 3);
        chk("bp_held", held, 3);
        chk("bp_done_k", done_k, 8);

        // zero length
        run(7, 0, 0, 0, 0, 10);
        chk("len0_done_k", done_k, 1);
        chk("len0_busy", busy_seen, 0);
        chk("len0_beats", q_idx.size(), 0);
        chk("len0_valid", first_valid_k, -1);

        // out-of-range base
        run(50, 2, 0, 0, 0, 20);
        check_beats("base50", 50, 2);

        // start during RUN is ignored
        run(0, 5, 0, 0, 2, 30);
        check_beats("midstart", 0, 5);
        chk("midstart_done_k", done_k, 7);

        // reset mid-window
        @(negedge clk);
        do_start(0, 10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_valid", cif.coef_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_addr", cif.rom_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(0, 2, 0, 0, 0, 20);
        check_beats("after_rst", 0, 2);
        chk("after_rst_done_k", done_k, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
